mdu_unit: RTL

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/mdu_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - MIPS-style multiply/divide unit with HI/LO registers
// Single-cycle multiplies and moves, 34-cycle restoring radix-2 divider.
module mdu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdu_en_i,
  input  logic [3:0]  mdu_op_i,
  input  logic [31:0] mdu_a_i,
  input  logic [31:0] mdu_b_i,
  input  logic        mdu_flush_i,
  output logic [31:0] mdu_result_o,
  output logic        mdu_busy_o
);

  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIV_RUN = 2'd1;
  localparam logic [1:0] S_DIV_FIX = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] dvd_raw;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic        neg_q;
  logic        neg_r;

  logic        accept;
  logic        is_signed;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic        ge;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign accept     = (state == S_IDLE) && mdu_en_i && !mdu_flush_i;
  assign mdu_busy_o = (state != S_IDLE);
  assign is_signed  = (mdu_op_i == OP_DIV);

  // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
  assign prod_s = {{32{mdu_a_i[31]}}, mdu_a_i} * {{32{mdu_b_i[31]}}, mdu_b_i};
  assign prod_u = {32'd0, mdu_a_i} * {32'd0, mdu_b_i};

  assign a_mag = (is_signed && mdu_a_i[31]) ? (32'd0 - mdu_a_i) : mdu_a_i;
  assign b_mag = (is_signed && mdu_b_i[31]) ? (32'd0 - mdu_b_i) : mdu_b_i;

  // quo starts as the dividend magnitude and shifts quotient bits in from the bottom.
  assign rem_sh   = {rem, quo[31]};
  assign rem_diff = rem_sh - {1'b0, dvs};
  assign ge       = !rem_diff[32];

  assign q_fix = neg_q ? (32'd0 - quo) : quo;
  assign r_fix = neg_r ? (32'd0 - rem) : rem;

  always_comb begin
    mdu_result_o = 32'd0;
    case (mdu_op_i)
      OP_MFHI: mdu_result_o = hi;
      OP_MFLO: mdu_result_o = lo;
      OP_MUL:  mdu_result_o = prod_s[31:0];
      default: mdu_result_o = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 5'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      dvd_raw <= 32'd0;
      quo     <= 32'd0;
      dvs     <= 32'd0;
      rem     <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (mdu_op_i)
              OP_MULT:  {hi, lo} <= prod_s;
              OP_MULTU: {hi, lo} <= prod_u;
              OP_MTHI:  hi <= mdu_a_i;
              OP_MTLO:  lo <= mdu_a_i;
              OP_DIV, OP_DIVU: begin
                dvd_raw <= mdu_a_i;
                quo     <= a_mag;
                dvs     <= b_mag;
                rem     <= 32'd0;
                cnt     <= 5'd0;
                neg_q   <= is_signed && (mdu_a_i[31] ^ mdu_b_i[31]);
                neg_r   <= is_signed && mdu_a_i[31];
                state   <= S_DIV_RUN;
              end
              default: ;
            endcase
          end
        end
        S_DIV_RUN: begin
          if (mdu_flush_i) begin
            state <= S_IDLE;
          end else begin
            rem <= ge ? rem_diff[31:0] : rem_sh[31:0];
            quo <= {quo[30:0], ge};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= S_DIV_FIX;
          end
        end
        S_DIV_FIX: begin
          state <= S_IDLE;
          if (!mdu_flush_i) begin
            // Divide-by-zero result is architecturally fixed rather than the raw iteration output.
            if (dvs == 32'd0) begin
              lo <= 32'hFFFF_FFFF;
              hi <= dvd_raw;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
